// File: rtl/skip_scan_if.sv
// Ring-side bundle for skip_scan.
// Ports (slave = the recovery block):
//   iCLK, sCLK, B0 : ring clock, skipped clock and position-0 marker into the block
//   MASK_OUT       : recovered skip pattern (bit k = 1 when slot k was skipped)
//   VALID, ERR     : one-mCLK pulses for frame completion / framing or pattern error
//   LOCK           : pattern stable for the required number of frames
//   POS            : current slot index
interface skip_scan_if #(
   parameter int unsigned LEN = 16
);
   localparam int unsigned POS_W = (LEN > 1) ? $clog2(LEN) : 1;

   logic             iCLK;
   logic             sCLK;
   logic             B0;
   logic [LEN-1:0]   MASK_OUT;
   logic             VALID;
   logic             LOCK;
   logic             ERR;
   logic [POS_W-1:0] POS;

   modport master (
      output iCLK, sCLK, B0,
      input  MASK_OUT, VALID, LOCK, ERR, POS
   );

   modport slave (
      input  iCLK, sCLK, B0,
      output MASK_OUT, VALID, LOCK, ERR, POS
   );
endinterface

// File: rtl/skip_scan.sv
// Recovers the clock-skip pattern of a LEN-slot ring by oversampling the
// ungated ring clock (iCLK), the skipped clock (sCLK) and the slot-0 marker
// (B0) on mCLK. Each iCLK falling edge closes a slot; a slot whose sCLK never
// pulsed is recorded as skipped. Frames are aligned to B0, compared against
// the previous frame, and declared locked after LOCKN identical frames.
// Ports:
//   mCLK  : sampling clock, all state on its rising edge
//   nRST  : asynchronous active-low reset
//   ring  : skip_scan_if slave (ring inputs, MASK_OUT/VALID/LOCK/ERR/POS outputs)
module skip_scan #(
   parameter int unsigned LEN   = 16,
   parameter int unsigned SYNC  = 2,
   parameter int unsigned LOCKN = 2
) (
   input  logic       mCLK,
   input  logic       nRST,
   skip_scan_if.slave ring
);

   localparam int unsigned POS_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int unsigned CNT_W = 4;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCKN);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CAPTURE = 2'd1,
      TRACK   = 2'd2
   } state_e;

   logic [SYNC-1:0]  iclk_sync_q, iclk_sync_d;
   logic [SYNC-1:0]  sclk_sync_q, sclk_sync_d;
   logic [SYNC-1:0]  b0_sync_q,   b0_sync_d;
   logic             iclk_prev_q, iclk_prev_d;
   logic             seen_q,      seen_d;
   state_e           state_q,     state_d;
   logic [POS_W-1:0] pos_q,       pos_d;
   logic [LEN-1:0]   frame_q,     frame_d;
   logic [LEN-1:0]   mask_q,      mask_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             lock_q,      lock_d;
   logic             valid_q,     valid_d;
   logic             err_q,       err_d;

   logic             iclk_s, sclk_s, b0_s;
   logic             close_c;
   logic             seen_now_c;
   logic             slot_bit_c;
   logic [LEN-1:0]   frame_next_c;
   logic             track_miss_c;

   assign iclk_s = iclk_sync_q[SYNC-1];
   assign sclk_s = sclk_sync_q[SYNC-1];
   assign b0_s   = b0_sync_q[SYNC-1];

   // Next-state logic: synchronizers, slot closing and framing FSM.
   always_comb begin
      iclk_sync_d  = {iclk_sync_q[SYNC-2:0], ring.iCLK};
      sclk_sync_d  = {sclk_sync_q[SYNC-2:0], ring.sCLK};
      b0_sync_d    = {b0_sync_q[SYNC-2:0], ring.B0};
      iclk_prev_d  = iclk_s;
      state_d      = state_q;
      pos_d        = pos_q;
      frame_d      = frame_q;
      mask_d       = mask_q;
      cnt_d        = cnt_q;
      lock_d       = lock_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;
      track_miss_c = 1'b0;

      close_c    = iclk_prev_q & ~iclk_s;
      // The closing cycle's own sample still counts toward this slot.
      seen_now_c = seen_q | (iclk_s & sclk_s);
      slot_bit_c = ~seen_now_c;
      seen_d     = seen_now_c;

      frame_next_c        = frame_q;
      frame_next_c[pos_q] = slot_bit_c;

      if (close_c) begin
         seen_d = 1'b0;
         if (state_q == HUNT) begin
            if (b0_s) begin
               frame_d    = '0;
               frame_d[0] = slot_bit_c;
               pos_d      = POS_W'(1);
               state_d    = CAPTURE;
            end
         end else if (b0_s && (pos_q != '0)) begin
            // Early marker: resync onto it, partial frame dropped.
            err_d      = 1'b1;
            lock_d     = 1'b0;
            cnt_d      = '0;
            frame_d    = '0;
            frame_d[0] = slot_bit_c;
            pos_d      = POS_W'(1);
            state_d    = CAPTURE;
         end else if (!b0_s && (pos_q == '0)) begin
            // Marker missing where slot 0 was expected: alignment lost.
            err_d   = 1'b1;
            lock_d  = 1'b0;
            cnt_d   = '0;
            pos_d   = '0;
            state_d = HUNT;
         end else begin
            frame_d = frame_next_c;
            if (pos_q == POS_LAST) begin
               pos_d   = '0;
               mask_d  = frame_next_c;
               valid_d = 1'b1;
               // A zero count means no reference frame yet: this one counts as 1.
               if (cnt_q == '0) begin
                  cnt_d = CNT_W'(1);
               end else if (frame_next_c == mask_q) begin
                  cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = CNT_W'(1);
               end
               track_miss_c = (state_q == TRACK) && (frame_next_c != mask_q);
               if (track_miss_c) begin
                  err_d   = 1'b1;
                  lock_d  = 1'b0;
                  state_d = CAPTURE;
               end else begin
                  lock_d  = (cnt_d >= CNT_MAX);
                  state_d = lock_d ? TRACK : CAPTURE;
               end
            end else begin
               pos_d = pos_q + POS_W'(1);
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge mCLK or negedge nRST) begin
      if (!nRST) begin
         iclk_sync_q <= '0;
         sclk_sync_q <= '0;
         b0_sync_q   <= '0;
         iclk_prev_q <= 1'b0;
         seen_q      <= 1'b0;
         state_q     <= HUNT;
         pos_q       <= '0;
         frame_q     <= '0;
         mask_q      <= '0;
         cnt_q       <= '0;
         lock_q      <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         iclk_sync_q <= iclk_sync_d;
         sclk_sync_q <= sclk_sync_d;
         b0_sync_q   <= b0_sync_d;
         iclk_prev_q <= iclk_prev_d;
         seen_q      <= seen_d;
         state_q     <= state_d;
         pos_q       <= pos_d;
         frame_q     <= frame_d;
         mask_q      <= mask_d;
         cnt_q       <= cnt_d;
         lock_q      <= lock_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign ring.MASK_OUT = mask_q;
   assign ring.VALID    = valid_q;
   assign ring.LOCK     = lock_q;
   assign ring.ERR      = err_q;
   assign ring.POS      = pos_q;

endmodule

// File: tb/tb_skip_scan.sv
// Scoreboard bench for skip_scan: a ring driver emits slots (iCLK/sCLK/B0),
// a frame-level reference model predicts every VALID/ERR event into a queue,
// and a monitor pops and compares whenever the DUT pulses VALID or ERR.
module tb_skip_scan;

   localparam int unsigned LEN   = 16;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned LOCKN = 2;

   typedef struct packed {
      logic           valid;
      logic           err;
      logic           lock;
      logic [LEN-1:0] mask;
   } ev_t;

   logic mclk = 1'b0;
   logic nrst = 1'b0;

   skip_scan_if #(.LEN(LEN)) ring_if ();

   skip_scan #(.LEN(LEN), .SYNC(SYNC), .LOCKN(LOCKN)) dut (
      .mCLK (mclk),
      .nRST (nrst),
      .ring (ring_if)
   );

   always #5 mclk = ~mclk;

   int  n_cmp = 0;
   int  n_bad = 0;
   ev_t exp_q[$];

   // Reference model: frame-level view of the ring.
   bit             m_hunt;
   bit             m_cur[$];
   logic [LEN-1:0] m_mask;
   int             m_run;
   bit             m_lock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hunt = 1'b1;
      m_cur.delete();
      m_mask = '0;
      m_run  = 0;
      m_lock = 1'b0;
   endtask

   task automatic push_ev(input bit v, input bit e, input bit l, input logic [LEN-1:0] m);
      ev_t ev;
      ev.valid = v;
      ev.err   = e;
      ev.lock  = l;
      ev.mask  = m;
      exp_q.push_back(ev);
   endtask

   // One slot has ended: skipped is 1 when sCLK stayed low, b0 the marker level.
   task automatic model_close(input bit skipped, input bit b0);
      logic [LEN-1:0] f;
      bit             changed;
      if (m_hunt) begin
         if (b0) begin
            m_hunt = 1'b0;
            m_cur.delete();
            m_cur.push_back(skipped);
         end
      end else if (b0 && m_cur.size() != 0) begin
         m_run  = 0;
         m_lock = 1'b0;
         push_ev(1'b0, 1'b1, 1'b0, m_mask);
         m_cur.delete();
         m_cur.push_back(skipped);
      end else if (!b0 && m_cur.size() == 0) begin
         m_run  = 0;
         m_lock = 1'b0;
         m_hunt = 1'b1;
         push_ev(1'b0, 1'b1, 1'b0, m_mask);
      end else begin
         m_cur.push_back(skipped);
         if (m_cur.size() == LEN) begin
            for (int k = 0; k < LEN; k++) f[k] = m_cur[k];
            m_cur.delete();
            changed = (f != m_mask);
            if (m_run == 0 || changed) m_run = 1;
            else if (m_run < LOCKN) m_run = m_run + 1;
            if (m_lock && changed) begin
               m_lock = 1'b0;
               push_ev(1'b1, 1'b1, 1'b0, f);
            end else begin
               m_lock = (m_run >= LOCKN);
               push_ev(1'b1, 1'b0, m_lock, f);
            end
            m_mask = f;
         end
      end
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      #1;
      chk("rst_mask",  32'(ring_if.MASK_OUT), 32'h0);
      chk("rst_valid", 32'(ring_if.VALID),    32'h0);
      chk("rst_lock",  32'(ring_if.LOCK),     32'h0);
      chk("rst_err",   32'(ring_if.ERR),      32'h0);
      chk("rst_pos",   32'(ring_if.POS),      32'h0);
      chk("rst_pending_events", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      model_reset();
      #24;
      @(negedge mclk);
      nrst = 1'b1;
   endtask

   // Drive nslots slots of a frame; B0 on slot b0_slot; reset in slot rst_slot.
   task automatic run_frame(input logic [LEN-1:0] mask, input int b0_slot,
                            input int nslots, input int rst_slot);
      bit skipped;
      for (int i = 0; i < nslots; i++) begin
         skipped      = mask[i];
         ring_if.B0   = (i == b0_slot);
         ring_if.iCLK = 1'b1;
         ring_if.sCLK = !skipped;
         #80;
         ring_if.iCLK = 1'b0;
         ring_if.sCLK = 1'b0;
         model_close(skipped, i == b0_slot);
         if (i == rst_slot) begin
            #40;
            do_reset();
            #40;
         end else begin
            #80;
         end
      end
   endtask

   // Monitor: every VALID/ERR pulse is matched against the next prediction.
   ev_t got, want;
   initial begin
      forever begin
         @(negedge mclk);
         if (nrst && (ring_if.VALID || ring_if.ERR)) begin
            got.valid = ring_if.VALID;
            got.err   = ring_if.ERR;
            got.lock  = ring_if.LOCK;
            got.mask  = ring_if.MASK_OUT;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event: got valid=%0b err=%0b lock=%0b mask=%h, none expected",
                        got.valid, got.err, got.lock, got.mask);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_bad++;
                  $display("FAIL event: got valid=%0b err=%0b lock=%0b mask=%h expected valid=%0b err=%0b lock=%0b mask=%h",
                           got.valid, got.err, got.lock, got.mask,
                           want.valid, want.err, want.lock, want.mask);
               end
            end
         end
      end
   end

   initial begin
      logic [LEN-1:0] rm, prev;
      int             kind;
      int             waited;
      ring_if.iCLK = 1'b0;
      ring_if.sCLK = 1'b0;
      ring_if.B0   = 1'b0;
      model_reset();
      #23;
      chk("init_mask",  32'(ring_if.MASK_OUT), 32'h0);
      chk("init_valid", 32'(ring_if.VALID),    32'h0);
      chk("init_lock",  32'(ring_if.LOCK),     32'h0);
      chk("init_err",   32'(ring_if.ERR),      32'h0);
      @(negedge mclk);
      nrst = 1'b1;
      repeat (3) @(negedge mclk);

      run_frame(16'h1234, -1, LEN, -1);            // no marker: nothing reported
      repeat (3) run_frame(16'hCCCC, 0, LEN, -1);  // steady pattern, lock on 2nd
      repeat (2) run_frame(16'h0001, 0, LEN, -1);  // pattern change while locked
      run_frame(16'h0001, 0, 5, -1);               // marker arrives early
      repeat (2) run_frame(16'h0001, 0, LEN, -1);
      run_frame(16'hA5A5, 0, LEN, 9);              // reset mid-frame
      repeat (2) run_frame(16'hA5A5, 0, LEN, -1);
      repeat (2) run_frame(16'hFFFF, 0, LEN, -1);  // sCLK stuck low
      repeat (2) run_frame(16'h0000, 0, LEN, -1);
      run_frame(16'h0000, -1, LEN, -1);            // marker missing for a frame
      repeat (2) run_frame(16'h3C3C, 0, LEN, -1);
      chk("lock_after_recovery", 32'(ring_if.LOCK), 32'h1);

      prev = 16'h3C3C;
      for (int it = 0; it < 24; it++) begin
         kind = $urandom_range(0, 9);
         rm   = (kind >= 5) ? prev : LEN'($urandom);
         if (kind == 0)      run_frame(rm, -1, LEN, -1);
         else if (kind == 1) run_frame(rm, 0, $urandom_range(1, LEN - 1), -1);
         else                repeat ($urandom_range(1, 3)) run_frame(rm, 0, LEN, -1);
         prev = rm;
      end

      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(negedge mclk);
         waited++;
      end
      chk("events_drained", 32'(exp_q.size()), 32'h0);
      chk("final_lock", 32'(ring_if.LOCK), 32'(m_lock));
      chk("final_pos",  32'(ring_if.POS),  32'(m_cur.size()));
      chk("final_mask", 32'(ring_if.MASK_OUT), 32'(m_mask));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/skip_scan.md
SKIP_SCAN -- requirements
Module: skip_scan

Interface
REQ-001 SHALL have parameter LEN, default 16, ring length in bits (2..32).
REQ-002 SHALL have parameter SYNC, default 2, synchronizer depth in mCLK flops (2..3).
REQ-003 SHALL have parameter LOCKN, default 2, consecutive identical frames required for lock (1..15).
REQ-004 SHALL have port mCLK input 1, sampling clock; all state on its rising edge.
REQ-005 SHALL have port nRST input 1, asynchronous active-low reset.
REQ-006 SHALL have port iCLK input 1, ungated ring clock; asynchronous to mCLK and at most mCLK/8.
REQ-007 SHALL have port sCLK input 1, skipped clock; equals iCLK when the slot is kept, and stays low for a skipped slot.
REQ-008 SHALL have port B0 input 1, ring position-0 marker; high during slot 0.
REQ-009 SHALL have port MASK_OUT output LEN, recovered skip pattern; bit k is 1 when slot k was skipped.
REQ-010 SHALL have port VALID output 1, one-mCLK pulse per completed frame.
REQ-011 SHALL have port LOCK output 1, level; pattern stable for LOCKN frames.
REQ-012 SHALL have port ERR output 1, one-mCLK pulse on a framing error or pattern mismatch.
REQ-013 SHALL have port POS output clog2(LEN), current slot index.

Function
REQ-014 SHALL pass iCLK, sCLK and B0 through SYNC-flop synchronizers, then one edge-detect register on iCLK.
REQ-015 SHALL set a per-slot seen flag when synced iCLK=1 and synced sCLK=1; the flag includes the sample from the falling-edge cycle.
REQ-016 SHALL close a slot on a detected iCLK falling edge: bit = NOT seen; then clear seen.
REQ-017 SHALL sample synced B0 at slot close; B0=1 marks the closing slot as position 0.
REQ-018 SHALL implement FSM states HUNT, CAPTURE and TRACK.
REQ-019 HUNT: discard bits until a slot closes with B0=1; store that bit at index 0; set POS=1; go to CAPTURE.
REQ-020 CAPTURE/TRACK: store each closed bit at index POS; increment POS, wrapping from LEN-1 to 0.
REQ-021 SHALL treat the slot closing at POS=LEN-1 as frame end: load the frame into MASK_OUT and pulse VALID exactly 1 mCLK later.
REQ-022 At frame end, SHALL compare the frame with the previous MASK_OUT: equal increments the match count (saturating at LOCKN); unequal sets the count to 1.
REQ-023 LOCK SHALL be 1 while match count >= LOCKN, and TRACK SHALL be entered at that point; the first frame after HUNT counts as 1.
REQ-024 A mismatch in TRACK SHALL pulse ERR, drop LOCK in the same cycle that VALID pulses, and return to CAPTURE.
REQ-025 B0=1 at a slot close with POS!=0 SHALL pulse ERR, clear LOCK and the match count, discard the partial frame, store the bit at index 0, and set POS=1 (resync, no VALID).
REQ-026 B0=0 at a slot close with POS=0 in CAPTURE/TRACK SHALL pulse ERR and go to HUNT, clearing LOCK.
REQ-027 On simultaneous frame-end and framing error, the framing error SHALL win: no VALID, MASK_OUT unchanged.
REQ-028 MASK_OUT SHALL hold its value between frames and through HUNT.

Reset
REQ-029 nRST low SHALL immediately clear all synchronizers, the FSM (to HUNT), POS, MASK_OUT, VALID, LOCK, ERR, the match count and the seen flag to 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; after release, no VALID is issued before a B0 slot is seen.
REQ-031 Release of nRST SHALL be assumed synchronous to mCLK (the integrator supplies the synchronizer).

Verification
REQ-032 LEN=16, mask 16'b1100110011001100, iCLK=mCLK/16, steady -> first VALID with MASK_OUT=16'hCCCC; LOCK rises at the 2nd VALID; no ERR.
REQ-033 Locked, then mask changed to 16'h0001 at a frame boundary -> next VALID shows 16'h0001 with ERR, LOCK=0; LOCK=1 again one frame later.
REQ-034 Locked, then B0 asserted at slot 5 -> ERR pulse, LOCK=0, no VALID for the truncated frame; VALID is issued 16 slots after the new B0.
REQ-035 nRST pulsed at slot 9 of a locked stream -> all outputs 0 at once; first VALID after the next B0 frame completes; LOCK after 2 frames.
REQ-036 Mask all-ones (sCLK stuck low) and all-zeros -> MASK_OUT=16'hFFFF and 16'h0000 respectively, LOCK reached.
REQ-037 B0 missing for one frame -> ERR at the POS=0 slot, HUNT entered, recovery on the next B0.
